// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_arb_pkg
//  Description : Shared types and constants for the SPI-flash AXI-lite
//                arbiter: FSM state encoding, owner encoding, grant vector
//                and the flash config register address.
//  Revision    : 1.0 - initial release
// ============================================================================
package flash_arb_pkg;

    // Arbiter FSM states, explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } arb_state_t;

    // Owner encoding: which master holds the in-flight transaction.
    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    // Flash controller configuration register (used by test benches).
    localparam logic [31:0] CFG_ADDR = 32'h0200_0000;

    // One-hot grant: M0 read, M1 read, M1 write.
    typedef struct packed {
        logic r0;
        logic r1;
        logic w1;
    } arb_grant_t;

endpackage
`default_nettype wire

// File: rtl/flash_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : flash_arb_rr_pick
//  Description : Two-way grant selection for the flash arbiter.
//                With FLASH_ARB_RR_EN defined, M0 and M1 alternate
//                (round-robin on i_last); otherwise M0 has fixed priority.
//                Inside M1 a complete write (AW and W both valid) always
//                beats a read.
//  Ports       : i_req_r0     - M0 read request
//                i_req_r1     - M1 read request
//                i_req_w1     - M1 write request (AW and W both valid)
//                i_last       - owner of the previous grant (RR build only)
//                o_gnt        - one-hot grant vector
//                o_gnt_any    - some request is present
//                o_gnt_owner  - owner of the winning request
//  Macro       : FLASH_ARB_RR_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_arb_rr_pick
    import flash_arb_pkg::*;
(
    input  logic       i_req_r0,
    input  logic       i_req_r1,
    input  logic       i_req_w1,
`ifdef FLASH_ARB_RR_EN
    input  logic       i_last,
`endif
    output arb_grant_t o_gnt,
    output logic       o_gnt_any,
    output logic       o_gnt_owner
);

    logic w_m1_req;
    logic w_m0_wins;

    always_comb begin
        w_m1_req = i_req_r1 | i_req_w1;
`ifdef FLASH_ARB_RR_EN
        // M0 takes the slot when M1 is silent or M1 owned the last grant.
        w_m0_wins = i_req_r0 & (~w_m1_req | (i_last == OWN_M1));
`else
        w_m0_wins = i_req_r0;
`endif
        o_gnt.r0    = w_m0_wins;
        o_gnt.w1    = ~w_m0_wins & i_req_w1;
        o_gnt.r1    = ~w_m0_wins & ~i_req_w1 & i_req_r1;
        o_gnt_any   = i_req_r0 | w_m1_req;
        o_gnt_owner = w_m0_wins ? OWN_M0 : OWN_M1;
    end

endmodule
`default_nettype wire

// File: rtl/flash_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : flash_axi_arbiter
//  Description : Two-master / one-slave AXI-lite arbiter in front of the SPI
//                flash memory-mapped slave. M0 (instruction fetch) is
//                read-only, M1 (data side) reads and writes. One transaction
//                is in flight at a time; responses go back to the owner.
//  Ports       : clk, reset          - clock, async active-high reset
//                m0_ar*, m0_r*       - M0 read address / read data
//                m1_aw*, m1_w*, m1_b* - M1 write address / data / response
//                m1_ar*, m1_r*       - M1 read address / read data
//                s_*                 - AXI-lite master port to flash slave
//  Macro       : FLASH_ARB_RR_EN - round-robin between masters when defined,
//                fixed M0 > M1 priority otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_axi_arbiter
    import flash_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    // M0: instruction fetch, read only
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_W-1:0]     m0_araddr,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_W-1:0]     m0_rdata,
    // M1: data side, read and write
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_W-1:0]     m1_araddr,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_W-1:0]     m1_rdata,
    // Slave port
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic [DATA_W-1:0]     s_rdata
);

    localparam int c_STRB_W = DATA_W / 8;

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic                  r_own;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [c_STRB_W-1:0]   r_wstrb;
    logic                  r_aw_done;
    logic                  r_w_done;
`ifdef FLASH_ARB_RR_EN
    logic                  r_last;
`endif

    arb_grant_t            w_gnt;
    logic                  w_gnt_any;
    logic                  w_gnt_owner;
    logic                  w_grant;
    logic                  w_aw_hs;
    logic                  w_w_hs;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    flash_arb_rr_pick u_pick (
        .i_req_r0    (m0_arvalid),
        .i_req_r1    (m1_arvalid),
        .i_req_w1    (m1_awvalid & m1_wvalid),
`ifdef FLASH_ARB_RR_EN
        .i_last      (r_last),
`endif
        .o_gnt       (w_gnt),
        .o_gnt_any   (w_gnt_any),
        .o_gnt_owner (w_gnt_owner)
    );

    assign w_grant = (r_state == IDLE) & w_gnt_any;
    assign w_aw_hs = s_awvalid & s_awready;
    assign w_w_hs  = s_wvalid & s_wready;

    // Slave-side address/data come straight from the latched request so
    // they are stable for the whole handshake.
    assign s_araddr = r_addr;
    assign s_awaddr = r_addr;
    assign s_wdata  = r_wdata;
    assign s_wstrb  = r_wstrb;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch, owner and write-channel completion flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_own     <= OWN_M0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef FLASH_ARB_RR_EN
            r_last    <= OWN_M1;
`endif
        end else if (w_grant) begin
            r_own     <= w_gnt_owner;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef FLASH_ARB_RR_EN
            r_last    <= w_gnt_owner;
`endif
            if (w_gnt.w1) begin
                r_addr  <= m1_awaddr;
                r_wdata <= m1_wdata;
                r_wstrb <= m1_wstrb;
            end else if (w_gnt.r0) begin
                r_addr  <= m0_araddr;
            end else begin
                r_addr  <= m1_araddr;
            end
        end else if (r_state == WR_ADDR) begin
            // AW and W may complete in different cycles; remember each.
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        m0_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m0_rdata    = '0;
        m1_awready  = 1'b0;
        m1_wready   = 1'b0;
        m1_bvalid   = 1'b0;
        m1_arready  = 1'b0;
        m1_rvalid   = 1'b0;
        m1_rdata    = '0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;

        case (r_state)
            IDLE: begin
                // Master readies only ever rise here, and only for the winner.
                if (w_gnt_any) begin
                    m0_arready  = w_gnt.r0;
                    m1_arready  = w_gnt.r1;
                    m1_awready  = w_gnt.w1;
                    m1_wready   = w_gnt.w1;
                    w_state_nxt = w_gnt.w1 ? WR_ADDR : RD_ADDR;
                end
            end

            RD_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready) begin
                    w_state_nxt = RD_DATA;
                end
            end

            RD_DATA: begin
                if (r_own == OWN_M1) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    s_rready  = m1_rready;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    s_rready  = m0_rready;
                end
                if (s_rvalid && s_rready) begin
                    w_state_nxt = IDLE;
                end
            end

            WR_ADDR: begin
                s_awvalid = ~r_aw_done;
                s_wvalid  = ~r_w_done;
                if ((r_aw_done || s_awready) && (r_w_done || s_wready)) begin
                    w_state_nxt = WR_RESP;
                end
            end

            WR_RESP: begin
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
                if (s_bvalid && m1_bready) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_axi_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_flash_axi_arbiter
//  Description : Self-checking bench for flash_axi_arbiter. Master agents
//                present queued requests, a behavioural flash slave answers
//                with programmable ready delays, and a scoreboard of granted
//                transactions is checked against slave and master traffic.
//                Expected arbitration follows FLASH_ARB_RR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_axi_arbiter;
    import flash_arb_pkg::*;

`ifdef FLASH_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct packed {
        logic        own;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    logic clk = 1'b0;
    logic reset;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;

    always #5 clk = ~clk;

    flash_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stimulus queues, scoreboard, grant log
    logic [31:0] m0_q[$];
    logic [31:0] m1r_q[$];
    txn_t        m1w_q[$];
    txn_t        sb[$];
    int          gnt_log[$];   // 0 = R0, 2 = R1, 3 = W1

    // Slave model configuration and state
    int          ar_dly, aw_dly, w_dly, stall_cfg, stall_seen;
    logic [31:0] cfg_reg;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == CFG_ADDR)      return cfg_reg;
        if (a == 32'h0010_0000) return 32'h1234_5678;
        return a ^ 32'h5A5A_3C3C;
    endfunction

    // Arbitration model
    logic mdl_busy, mdl_last, mdl_own, prev_grant, prev_wr;

    // Negedge snapshots consumed by the driver at the next posedge
    logic sn_m0ar, sn_m1ar, sn_m1w, sn_m0rv;
    logic sn_sar_v, sn_sar_hs, sn_saw_v, sn_saw_hs, sn_sw_v, sn_sw_hs, sn_sr_hs, sn_sb_hs;
    logic [31:0] sn_araddr, sn_awaddr, sn_wdata;

    // ------------------------------------------------------------------
    // Monitor / checker
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [2:0] exp_g;
        logic [2:0] got_g;
        logic       r0, r1, w1, m0w;
        txn_t       t;
        if (reset) begin
            check_eq("rst_ctrl", {m0_arready, m0_rvalid, m1_awready, m1_wready, m1_bvalid,
                                  m1_arready, m1_rvalid, s_awvalid, s_wvalid, s_bready,
                                  s_arvalid, s_rready}, 12'h0);
            check_eq("rst_data", s_araddr | s_awaddr | s_wdata | m0_rdata | m1_rdata
                                 | {28'h0, s_wstrb}, 64'h0);
            mdl_busy = 1'b0; mdl_last = 1'b1; prev_grant = 1'b0;
            sb.delete();
            {sn_m0ar, sn_m1ar, sn_m1w, sn_m0rv, sn_sar_v, sn_sar_hs, sn_saw_v, sn_saw_hs,
             sn_sw_v, sn_sw_hs, sn_sr_hs, sn_sb_hs} = '0;
        end else begin
            if (prev_grant)
                check_eq("req_latency", {s_arvalid, s_awvalid, s_wvalid},
                         prev_wr ? 3'b011 : 3'b100);
            prev_grant = 1'b0;

            r0 = m0_arvalid; r1 = m1_arvalid; w1 = m1_awvalid && m1_wvalid;
            exp_g = 3'b000;
            if (!mdl_busy && (r0 || r1 || w1)) begin
                m0w = r0 && (!(r1 || w1) || !RR || mdl_last);
                exp_g = m0w ? 3'b100 : (w1 ? 3'b001 : 3'b010);
            end
            got_g = {m0_arready, m1_arready, m1_awready && m1_wready};
            check_eq("grant", got_g, exp_g);
            check_eq("aw_w_ready_pair", m1_awready, m1_wready);
            if (exp_g != 3'b000) begin
                t = '0;
                t.own = !exp_g[2];
                t.wr  = exp_g[0];
                t.addr = exp_g[2] ? m0_araddr : (exp_g[0] ? m1_awaddr : m1_araddr);
                t.data = m1_wdata;
                t.strb = m1_wstrb;
                sb.push_back(t);
                gnt_log.push_back(exp_g[2] ? 0 : (exp_g[0] ? 3 : 2));
                mdl_busy = 1'b1; mdl_own = t.own; mdl_last = t.own;
                prev_grant = 1'b1; prev_wr = t.wr;
            end

            // Slave-side transfers must carry the granted request
            if (s_arvalid && s_arready) begin
                check_eq("sb_depth_ar", sb.size(), 1);
                if (sb.size() > 0) check_eq("s_araddr", s_araddr, sb[0].addr);
            end
            if (s_awvalid && s_awready) begin
                check_eq("sb_depth_aw", sb.size(), 1);
                if (sb.size() > 0) check_eq("s_awaddr", s_awaddr, sb[0].addr);
            end
            if (s_wvalid && s_wready && sb.size() > 0)
                check_eq("s_wdata_strb", {s_wdata, s_wstrb}, {sb[0].data, sb[0].strb});

            // Routing isolation
            if (mdl_busy && mdl_own == OWN_M0)
                check_eq("m1_quiet", {m1_rvalid, m1_bvalid}, 2'b00);
            if (mdl_busy && mdl_own == OWN_M1)
                check_eq("m0_quiet", m0_rvalid, 1'b0);

            // Owner stall: slave must see rready low, data held
            if (m0_rvalid && !m0_rready) begin
                stall_seen++;
                check_eq("stall_s_rready", s_rready, 1'b0);
                if (sb.size() > 0) check_eq("stall_rdata", m0_rdata, rd_fn(sb[0].addr));
            end

            // Responses complete the scoreboard entry
            if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready) || (m1_bvalid && m1_bready)) begin
                check_eq("sb_depth_resp", sb.size(), 1);
                if (sb.size() > 0) begin
                    t = sb.pop_front();
                    if (m0_rvalid) begin
                        check_eq("m0_resp_kind", {t.own, t.wr}, 2'b00);
                        check_eq("m0_rdata", m0_rdata, rd_fn(t.addr));
                    end else if (m1_rvalid) begin
                        check_eq("m1_resp_kind", {t.own, t.wr}, 2'b10);
                        check_eq("m1_rdata", m1_rdata, rd_fn(t.addr));
                    end else begin
                        check_eq("m1_b_kind", {t.own, t.wr}, 2'b11);
                    end
                end
                mdl_busy = 1'b0;
            end

            sn_m0ar   = m0_arvalid && m0_arready;
            sn_m1ar   = m1_arvalid && m1_arready;
            sn_m1w    = m1_awvalid && m1_awready && m1_wvalid && m1_wready;
            sn_m0rv   = m0_rvalid;
            sn_sar_v  = s_arvalid;  sn_sar_hs = s_arvalid && s_arready;
            sn_saw_v  = s_awvalid;  sn_saw_hs = s_awvalid && s_awready;
            sn_sw_v   = s_wvalid;   sn_sw_hs  = s_wvalid && s_wready;
            sn_sr_hs  = s_rvalid && s_rready;
            sn_sb_hs  = s_bvalid && s_bready;
            sn_araddr = s_araddr; sn_awaddr = s_awaddr; sn_wdata = s_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Master agents and flash slave model (drive #1 after posedge)
    // ------------------------------------------------------------------
    initial begin
        int          ar_wait, aw_wait, w_wait, m0_hold;
        logic        rd_pend, aw_got, w_got;
        logic [31:0] rd_data, dummy;
        txn_t        dw;
        {m0_arvalid, m0_araddr, m1_awvalid, m1_awaddr, m1_wvalid, m1_wdata, m1_wstrb} = '0;
        {m1_arvalid, m1_araddr, s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} = '0;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        cfg_reg = 32'h0;
        ar_wait = 0; aw_wait = 0; w_wait = 0; m0_hold = 0;
        rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                {m0_arvalid, m1_arvalid, m1_awvalid, m1_wvalid} = '0;
                {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata} = '0;
                ar_wait = 0; aw_wait = 0; w_wait = 0; m0_hold = 0;
                rd_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
                m0_rready = 1'b1;
            end else begin
                if (sn_m0ar) begin dummy = m0_q.pop_front(); m0_hold = stall_cfg; end
                if (sn_m1ar) dummy = m1r_q.pop_front();
                if (sn_m1w)  dw = m1w_q.pop_front();
                m0_arvalid = (m0_q.size() > 0);
                m0_araddr  = m0_arvalid ? m0_q[0] : 32'h0;
                m1_arvalid = (m1r_q.size() > 0);
                m1_araddr  = m1_arvalid ? m1r_q[0] : 32'h0;
                m1_awvalid = (m1w_q.size() > 0);
                m1_wvalid  = m1_awvalid;
                if (m1_awvalid) begin
                    m1_awaddr = m1w_q[0].addr; m1_wdata = m1w_q[0].data; m1_wstrb = m1w_q[0].strb;
                end
                if (sn_m0rv && m0_hold > 0) m0_hold--;
                m0_rready = (m0_hold == 0);

                // Read channel
                if (sn_sar_hs) begin
                    s_arready = 1'b0; ar_wait = 0; rd_pend = 1'b1; rd_data = rd_fn(sn_araddr);
                end else if (sn_sar_v) begin
                    ar_wait++; s_arready = (ar_wait > ar_dly);
                end
                if (sn_sr_hs) begin s_rvalid = 1'b0; s_rdata = '0; end
                if (rd_pend) begin s_rvalid = 1'b1; s_rdata = rd_data; rd_pend = 1'b0; end

                // Write channels
                if (sn_saw_hs) begin
                    s_awready = 1'b0; aw_wait = 0; aw_got = 1'b1;
                end else if (sn_saw_v) begin
                    aw_wait++; s_awready = (aw_wait > aw_dly);
                end
                if (sn_sw_hs) begin
                    s_wready = 1'b0; w_wait = 0; w_got = 1'b1;
                    if (sn_awaddr == CFG_ADDR) cfg_reg = sn_wdata;
                end else if (sn_sw_v) begin
                    w_wait++; s_wready = (w_wait > w_dly);
                end
                if (sn_sb_hs) s_bvalid = 1'b0;
                if (aw_got && w_got) begin s_bvalid = 1'b1; aw_got = 1'b0; w_got = 1'b0; end
            end
        end
    end

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while ((m0_q.size() > 0 || m1r_q.size() > 0 || m1w_q.size() > 0 || sb.size() > 0 || mdl_busy)
               && n < max_cyc) begin
            @(posedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, (n >= max_cyc), 1'b0);
        @(posedge clk);
    endtask

    task automatic check_log(input string tag, input int e[$]);
        check_eq({tag, "_len"}, gnt_log.size(), e.size());
        foreach (e[i])
            if (i < gnt_log.size()) check_eq($sformatf("%s_%0d", tag, i), gnt_log[i], e[i]);
    endtask

    function automatic txn_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t = '0;
        t.own = 1'b1; t.wr = 1'b1; t.addr = a; t.data = d; t.strb = s;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        int n;
        reset = 1'b1;
        ar_dly = 0; aw_dly = 0; w_dly = 0; stall_cfg = 0; stall_seen = 0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // M0 read with slow address ready
        ar_dly = 2;
        m0_q.push_back(32'h0010_0000);
        wait_done("m0_read", 40);
        ar_dly = 0;

        // M1 config write, AW accepted before W, then read it back
        aw_dly = 0; w_dly = 2;
        m1w_q.push_back(mk_wr(CFG_ADDR, 32'h8000_0000, 4'hF));
        wait_done("m1_write", 40);
        w_dly = 0;
        m1r_q.push_back(CFG_ADDR);
        wait_done("cfg_read", 40);
        check_eq("cfg_reg", cfg_reg, 32'h8000_0000);

        // Both masters streaming reads
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            m0_q.push_back(32'h0010_0100 + 32'(i * 4));
            m1r_q.push_back(32'h0000_2000 + 32'(i * 4));
        end
        wait_done("stream", 200);
        if (RR) e = '{0, 2, 0, 2, 0, 2, 0, 2};
        else    e = '{0, 0, 0, 0, 2, 2, 2, 2};
        check_log("stream_seq", e);

        // R0, R1 and W1 together after an M0 grant
        m0_q.push_back(32'h0010_0200);
        wait_done("pre_mix", 40);
        gnt_log.delete();
        m0_q.push_back(32'h0010_0300);
        m0_q.push_back(32'h0010_0304);
        m1r_q.push_back(32'h0000_3000);
        m1w_q.push_back(mk_wr(CFG_ADDR, 32'h0000_00A5, 4'h1));
        wait_done("mix", 120);
        if (RR) e = '{3, 0, 2, 0};
        else    e = '{0, 0, 3, 2};
        check_log("mix_seq", e);

        // Owner holds rready low for 5 cycles
        stall_cfg = 5; stall_seen = 0;
        m0_q.push_back(32'h0010_0400);
        wait_done("stall", 60);
        check_eq("stall_cycles", stall_seen, 5);
        stall_cfg = 0;

        // Reset while in RD_DATA, then a normal M1 read
        stall_cfg = 10;
        m0_q.push_back(32'h0010_0500);
        n = 0;
        while (!m0_rvalid && n < 30) begin @(negedge clk); n++; end
        check_eq("rd_data_reach_timeout", (n >= 30), 1'b0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        stall_cfg = 0;
        m1r_q.push_back(32'h0000_4000);
        wait_done("post_reset", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
